// File: rtl/truth_table_checker.sv
// Drives all four input combinations onto a 2-input gate under test, waits a
// programmable settle time per vector and compares the gate output to TRUTH_TABLE.
module truth_table_checker #(
  parameter logic [3:0] TRUTH_TABLE   = 4'b1000,
  parameter int         SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       in0,
  output logic       in1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic       sample_now;
  logic       mismatch;
  logic [3:0] fail_mask_nxt;

  assign sample_now = (state == DRIVE) && (settle_cnt == LAST_CNT);
  assign mismatch   = dut_out != TRUTH_TABLE[vec_idx];

  // Mask including the vector sampled this cycle, so the final pass sees all four.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fail_mask_nxt          = fail_mask;
    fail_mask_nxt[vec_idx] = mismatch;
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (sample_now && (vec_idx == 2'd3)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_idx    <= 2'd0;
      settle_cnt <= 4'd0;
      fail_mask  <= 4'b0000;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec_idx    <= 2'd0;
            settle_cnt <= 4'd0;
            fail_mask  <= 4'b0000;
            pass       <= 1'b0;
          end
        end
        DRIVE: begin
          if (sample_now) begin
            fail_mask  <= fail_mask_nxt;
            settle_cnt <= 4'd0;
            if (vec_idx == 2'd3) pass    <= ~|fail_mask_nxt;
            else                 vec_idx <= vec_idx + 2'd1;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only; stimulus is parked at 0 outside DRIVE.
  assign busy       = (state == DRIVE);
  assign done       = (state == DONE);
  assign {in1, in0} = busy ? vec_idx : 2'b00;

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench: four checker instances against AND, OR, slow AND and stuck-at-1
// gates; expected results are queued at start and compared when done appears.
module tb_truth_table_checker;

  typedef struct {
    int         sel;
    logic [3:0] mask;
    logic       exp_pass;
  } exp_t;

  localparam logic [3:0] TT = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start_v;
  logic [3:0] gin0, gin1, gout, busy_v, done_v, pass_v;
  logic [3:0] fm_v [4];
  logic [1:0] vi_v [4];

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Gate models: AND, OR, AND (slow settle), stuck-at-1.
  assign gout[0] = gin0[0] & gin1[0];
  assign gout[1] = gin0[1] | gin1[1];
  assign gout[2] = gin0[2] & gin1[2];
  assign gout[3] = 1'b1;

  truth_table_checker #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(1)) u_and (
    .clk(clk), .rst(rst), .start(start_v[0]), .dut_out(gout[0]), .in0(gin0[0]), .in1(gin1[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .fail_mask(fm_v[0]), .vec_idx(vi_v[0]));
  truth_table_checker #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(1)) u_or (
    .clk(clk), .rst(rst), .start(start_v[1]), .dut_out(gout[1]), .in0(gin0[1]), .in1(gin1[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .fail_mask(fm_v[1]), .vec_idx(vi_v[1]));
  truth_table_checker #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(3)) u_slow (
    .clk(clk), .rst(rst), .start(start_v[2]), .dut_out(gout[2]), .in0(gin0[2]), .in1(gin1[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .fail_mask(fm_v[2]), .vec_idx(vi_v[2]));
  truth_table_checker #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(1)) u_stuck (
    .clk(clk), .rst(rst), .start(start_v[3]), .dut_out(gout[3]), .in0(gin0[3]), .in1(gin1[3]),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .fail_mask(fm_v[3]), .vec_idx(vi_v[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int settle_of(input int sel);
    return (sel == 2) ? 3 : 1;
  endfunction

  function automatic logic gate_model(input int sel, input int k);
    logic a, b;
    a = k[0];
    b = k[1];
    case (sel)
      1:       return a | b;
      3:       return 1'b1;
      default: return a & b;
    endcase
  endfunction

  task automatic push_exp(input int sel);
    exp_t e;
    e.sel = sel;
    e.mask = '0;
    for (int k = 0; k < 4; k++) e.mask[k] = gate_model(sel, k) != TT[k];
    e.exp_pass = (e.mask == 4'b0000);
    sb.push_back(e);
  endtask

  // Called on the sample where done is high.
  task automatic pop_compare(input int sel);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("sb_sel", sel, e.sel);
    check("fail_mask", fm_v[sel], e.mask);
    check("pass", pass_v[sel], e.exp_pass);
    check("vec_idx_end", vi_v[sel], 3);
    check("done_stim", {gin1[sel], gin0[sel]}, 0);
    check("done_busy", busy_v[sel], 0);
  endtask

  task automatic wait_done(input int sel, output int n);
    n = 0;
    while (!done_v[sel] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done_v[sel], 1);
  endtask

  task automatic run(input int sel, input bit repulse);
    int  s, n;
    logic held_pass;
    s = settle_of(sel);
    push_exp(sel);
    @(negedge clk); start_v[sel] = 1'b1;
    @(negedge clk); start_v[sel] = 1'b0;
    check("start_clr_mask", fm_v[sel], 0);
    check("start_clr_pass", pass_v[sel], 0);
    n = 0;
    while (!done_v[sel] && n < 200) begin
      check("busy", busy_v[sel], 1);
      check("vec", {gin1[sel], gin0[sel]}, n / s);
      if (repulse && n == 1) start_v[sel] = 1'b1;
      if (repulse && n == 2) start_v[sel] = 1'b0;
      @(negedge clk);
      n++;
    end
    check("done_seen", done_v[sel], 1);
    check("done_latency", n, 4 * s);
    pop_compare(sel);
    held_pass = pass_v[sel];
    @(negedge clk);
    check("done_one_cycle", done_v[sel], 0);
    check("idle_busy", busy_v[sel], 0);
    @(negedge clk);
    check("no_restart", busy_v[sel], 0);
    check("pass_held", pass_v[sel], held_pass);
  endtask

  // start held high: two back-to-back runs, restart must clear fail_mask and pass.
  task automatic held_run(input int sel);
    int n;
    push_exp(sel);
    push_exp(sel);
    @(negedge clk); start_v[sel] = 1'b1;
    wait_done(sel, n);
    pop_compare(sel);
    n = 0;
    while (!busy_v[sel] && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("restart_busy", busy_v[sel], 1);
    check("restart_clr_mask", fm_v[sel], 0);
    check("restart_clr_pass", pass_v[sel], 0);
    wait_done(sel, n);
    check("rerun_latency", n, 4 * settle_of(sel));
    pop_compare(sel);
    start_v[sel] = 1'b0;
    @(negedge clk);
    check("held_done_one_cycle", done_v[sel], 0);
  endtask

  task automatic reset_mid_run();
    bit saw_done;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_vec", {gin1[0], gin0[0]}, 2);
    #2 rst = 1'b1;
    #1;
    check("rst_async_stim", {gin1[0], gin0[0]}, 0);
    check("rst_async_busy", busy_v[0], 0);
    check("rst_async_done", done_v[0], 0);
    check("rst_async_pass", pass_v[0], 0);
    check("rst_async_mask", fm_v[0], 0);
    check("rst_async_vidx", vi_v[0], 0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) saw_done = 1'b1;
    end
    check("no_done_after_abort", saw_done, 0);
  endtask

  initial begin
    rst     = 1'b1;
    start_v = '0;
    #3;
    for (int i = 0; i < 4; i++) begin
      check("rst_stim", {gin1[i], gin0[i]}, 0);
      check("rst_busy", busy_v[i], 0);
      check("rst_done", done_v[i], 0);
      check("rst_pass", pass_v[i], 0);
      check("rst_mask", fm_v[i], 0);
      check("rst_vidx", vi_v[i], 0);
    end
    @(negedge clk);
    @(negedge clk); rst = 1'b0;

    run(0, 1'b1);  // AND, with an ignored start pulse during DRIVE
    run(0, 1'b0);  // restart after a passing run clears pass
    run(1, 1'b0);  // OR -> 0110
    run(2, 1'b0);  // SETTLE_CYCLES=3
    run(3, 1'b0);  // stuck-at-1 -> 0111
    held_run(1);
    reset_mid_run();
    run(0, 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
